// File: rtl/lut_neuron_pipe.sv
// -----------------------------------------------------------------------------
// lut_neuron_pipe
// Run-time loadable LogicNets neuron: maps an IN_W-bit fan-in vector to an
// OUT_W-bit activation through a 2**IN_W x OUT_W table held in distributed RAM.
// The table is filled over a serial config port. Lookups flow through a 2-stage
// valid/ready pipeline, so neurons can be chained layer to layer.
//
// Optional feature macro: LUT_PARITY_EN
//   Each table entry carries an even-parity bit. A bad read raises parity_err
//   alongside out_valid, and err_sticky latches it until rst or cfg_start.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cfg_start                pulse: (re)load the table from address 0
//   cfg_valid, cfg_data      next table word (honoured only while loading)
//   cfg_busy                 draining or loading
//   cfg_done                 one-cycle pulse on the write of the last word
//   lut_ready                table valid, lookups accepted
//   in_valid/in_ready/in_data      lookup request (in_data is the address)
//   out_valid/out_ready/out_data   lookup result
//   parity_err, err_sticky   (LUT_PARITY_EN only) read parity error flags
// -----------------------------------------------------------------------------
module lut_neuron_pipe #(
   parameter int unsigned IN_W  = 7,
   parameter int unsigned OUT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic [OUT_W-1:0] cfg_data,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             lut_ready,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef LUT_PARITY_EN
   output logic [OUT_W-1:0] out_data,
   output logic             parity_err,
   output logic             err_sticky
`else
   output logic [OUT_W-1:0] out_data
`endif
);

   localparam int unsigned DEPTH = 2**IN_W;
`ifdef LUT_PARITY_EN
   localparam int unsigned MEM_W = OUT_W + 1;
`else
   localparam int unsigned MEM_W = OUT_W;
`endif
   localparam logic [IN_W-1:0] LAST_ADDR = {IN_W{1'b1}};

   typedef enum logic [1:0] {StEmpty, StDrain, StLoad, StReady} state_e;

   state_e           r_state, w_state_nxt;
   logic [IN_W-1:0]  r_addr, w_addr_nxt;
   logic             w_wr_en;
   logic [IN_W-1:0]  w_wr_addr;
   logic [MEM_W-1:0] w_wr_word;
   logic [MEM_W-1:0] w_rd_word;
   logic [MEM_W-1:0] r_mem [DEPTH];

   logic             r_v1, r_v2;
   logic [IN_W-1:0]  r_addr1;
   logic [OUT_W-1:0] r_out_data;
   logic             w_en1, w_en2, w_accept;

   // ---------------- configuration FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StEmpty;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_wr_en     = 1'b0;
      cfg_done    = 1'b0;
      unique case (r_state)
         StEmpty: begin
            if (cfg_start) begin
               w_state_nxt = StLoad;
               w_addr_nxt  = '0;
            end
         end
         StLoad: begin
            if (cfg_start) begin
               // Restart: a coincident word lands at address 0.
               w_wr_en    = cfg_valid;
               w_addr_nxt = cfg_valid ? IN_W'(1) : '0;
            end else if (cfg_valid) begin
               w_wr_en = 1'b1;
               if (r_addr == LAST_ADDR) begin
                  cfg_done    = 1'b1;
                  w_state_nxt = StReady;
                  w_addr_nxt  = '0;
               end else begin
                  w_addr_nxt = r_addr + IN_W'(1);
               end
            end
         end
         StReady: begin
            if (cfg_start) w_state_nxt = StDrain;
         end
         StDrain: begin
            if (!r_v1 && !r_v2) begin
               w_state_nxt = StLoad;
               w_addr_nxt  = '0;
            end
         end
         default: w_state_nxt = StEmpty;
      endcase
   end

   assign cfg_busy  = (r_state == StDrain) || (r_state == StLoad);
   assign lut_ready = (r_state == StReady);

   // ---------------- table storage (not reset) ----------------
   assign w_wr_addr = cfg_start ? '0 : r_addr;
`ifdef LUT_PARITY_EN
   assign w_wr_word = {^cfg_data, cfg_data};
`else
   assign w_wr_word = cfg_data;
`endif

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_addr] <= w_wr_word;
   end

   assign w_rd_word = r_mem[r_addr1];

   // ---------------- lookup pipeline ----------------
   assign w_en2    = !r_v2 || out_ready;
   assign w_en1    = !r_v1 || w_en2;
   assign in_ready = (r_state == StReady) && w_en1;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         r_addr1    <= '0;
         r_out_data <= '0;
      end else begin
         if (w_accept) begin
            r_addr1 <= in_data;
            r_v1    <= 1'b1;
         end else if (w_en1) begin
            r_v1 <= 1'b0;
         end
         if (w_en2) begin
            r_out_data <= w_rd_word[OUT_W-1:0];
            r_v2       <= r_v1;
         end
      end
   end

   assign out_valid = r_v2;
   assign out_data  = r_out_data;

`ifdef LUT_PARITY_EN
   logic w_rd_err;
   logic r_parity_err, r_err_sticky;

   // Even parity over data plus stored bit must reduce to 0.
   assign w_rd_err = ^w_rd_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity_err <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         if (w_en2) r_parity_err <= r_v1 && w_rd_err;
         if (cfg_start) begin
            r_err_sticky <= 1'b0;
         end else if (w_en2 && r_v1 && w_rd_err) begin
            r_err_sticky <= 1'b1;
         end
      end
   end

   assign parity_err = r_parity_err;
   assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// -----------------------------------------------------------------------------
// tb_lut_neuron_pipe
// Directed bench for lut_neuron_pipe (IN_W = 7, OUT_W = 2): table load, streaming
// lookups, backpressure, drain-and-reload, reset mid-load and, with
// LUT_PARITY_EN, a backdoor parity fault. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lut_neuron_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_start, cfg_valid;
   logic [1:0] cfg_data;
   logic       cfg_busy, cfg_done, lut_ready;
   logic       in_valid, in_ready;
   logic [6:0] in_data;
   logic       out_valid, out_ready;
   logic [1:0] out_data;
`ifdef LUT_PARITY_EN
   logic       parity_err, err_sticky;
`endif

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lut_neuron_pipe #(.IN_W(7), .OUT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .lut_ready (lut_ready),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef LUT_PARITY_EN
      .out_data  (out_data),
      .parity_err(parity_err),
      .err_sticky(err_sticky)
`else
      .out_data  (out_data)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_cfg_busy"}, cfg_busy, 0);
      chk({tag, "_cfg_done"}, cfg_done, 0);
      chk({tag, "_lut_ready"}, lut_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   // One cycle of lookup traffic; a negative expectation skips that check.
   task automatic step(input string tag, input logic iv, input logic [6:0] id,
                       input logic ordy, input int e_ir, input int e_ov, input int e_od);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      @(negedge clk);
      if (e_ir >= 0) chk({tag, "_in_ready"}, in_ready, e_ir);
      if (e_ov >= 0) chk({tag, "_out_valid"}, out_valid, e_ov);
      if (e_od >= 0) chk({tag, "_out_data"}, out_data, e_od);
      adv();
   endtask

   // Feeds all 128 words, assuming the DUT is already in LOAD at address 0.
   // mode 0: table[i] = i % 4; mode 1: table[i] = 3 - i % 4.
   task automatic load_words(input string tag, input int mode);
      int done_cnt;
      int done_at;
      int busy_bad;
      int ir_bad;
      done_cnt = 0;
      done_at  = -1;
      busy_bad = 0;
      ir_bad   = 0;
      in_valid = 1'b0;
      for (int i = 0; i < 128; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = (mode == 0) ? 2'(i % 4) : 2'(3 - i % 4);
         @(negedge clk);
         if (cfg_done) begin
            done_cnt++;
            done_at = i;
         end
         if (!cfg_busy) busy_bad++;
         if (in_ready) ir_bad++;
         adv();
      end
      cfg_valid = 1'b0;
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_addr"}, done_at, 127);
      chk({tag, "_busy_low"}, busy_bad, 0);
      chk({tag, "_in_ready_high"}, ir_bad, 0);
      @(negedge clk);
      chk({tag, "_lut_ready_after"}, lut_ready, 1);
      chk({tag, "_busy_after"}, cfg_busy, 0);
      chk({tag, "_done_after"}, cfg_done, 0);
      adv();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // ---- reset ----
      adv();
      adv();
      @(negedge clk);
      chk_all_zero("reset");
      adv();
      rst = 1'b0;

      // ---- first load, table[i] = i % 4 ----
      cfg_start = 1'b1;
      step("start0", 0, 7'h00, 0, 0, 0, -1);
      cfg_start = 1'b0;
      load_words("load0", 0);

      // ---- back-to-back stream: 0x2B, 0x04, 0x7F -> 3, 0, 3 ----
      step("s0", 1, 7'h2B, 1, 1, 0, -1);
      step("s1", 1, 7'h04, 1, 1, 0, -1);
      step("s2", 1, 7'h7F, 1, 1, 1, 3);
      step("s3", 0, 7'h00, 1, 1, 1, 0);
      step("s4", 0, 7'h00, 1, 1, 1, 3);
      step("s5", 0, 7'h00, 1, 1, 0, -1);

      // ---- backpressure: out_ready low for 5 cycles ----
      step("bp0", 1, 7'h11, 0, 1, 0, -1);
      step("bp1", 1, 7'h22, 0, 1, 0, -1);
      step("bp2", 1, 7'h33, 0, 0, 1, 1);
      step("bp3", 1, 7'h33, 0, 0, 1, 1);
      step("bp4", 1, 7'h33, 0, 0, 1, 1);
      step("bp5", 1, 7'h33, 1, 1, 1, 1);
      step("bp6", 0, 7'h00, 1, 1, 1, 2);
      step("bp7", 0, 7'h00, 1, 1, 1, 3);
      step("bp8", 0, 7'h00, 1, 1, 0, -1);

      // ---- reload while two lookups are in flight ----
      step("d0", 1, 7'h05, 0, 1, 0, -1);
      step("d1", 1, 7'h06, 0, 1, 0, -1);
      cfg_start = 1'b1;
      step("d2", 0, 7'h00, 0, 0, 1, 1);
      cfg_start = 1'b0;
      // Words offered during DRAIN must be ignored.
      cfg_valid = 1'b1;
      cfg_data  = 2'b00;
      @(negedge clk);
      chk("d3_cfg_busy", cfg_busy, 1);
      chk("d3_lut_ready", lut_ready, 0);
      chk("d3_in_ready", in_ready, 0);
      chk("d3_out_valid", out_valid, 1);
      chk("d3_out_data", out_data, 1);
      adv();
      step("d4", 0, 7'h00, 0, 0, 1, 1);
      step("d5", 0, 7'h00, 1, 0, 1, 1);
      step("d6", 0, 7'h00, 1, 0, 1, 2);
      @(negedge clk);
      chk("d7_cfg_busy", cfg_busy, 1);
      chk("d7_cfg_done", cfg_done, 0);
      chk("d7_out_valid", out_valid, 0);
      adv();
      load_words("load1", 1);
      step("r0", 1, 7'h2B, 1, 1, 0, -1);
      step("r1", 1, 7'h04, 1, 1, 0, -1);
      step("r2", 0, 7'h00, 1, 1, 1, 0);
      step("r3", 0, 7'h00, 1, 1, 1, 3);
      step("r4", 0, 7'h00, 1, 1, 0, -1);

      // ---- reset at load address 60 ----
      cfg_start = 1'b1;
      step("m0", 0, 7'h00, 1, 1, 0, -1);
      cfg_start = 1'b0;
      step("m1", 0, 7'h00, 1, 0, 0, -1);
      for (int i = 0; i < 60; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = 2'(i % 4);
         adv();
      end
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      adv();
      rst = 1'b0;
      // EMPTY: lookups refused, config words ignored.
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'b1;
         in_data   = 7'h2B;
         cfg_valid = 1'b1;
         cfg_data  = 2'b11;
         @(negedge clk);
         chk("empty_in_ready", in_ready, 0);
         chk("empty_lut_ready", lut_ready, 0);
         chk("empty_cfg_busy", cfg_busy, 0);
         adv();
      end
      cfg_valid = 1'b0;
      cfg_start = 1'b1;
      step("m2", 1, 7'h2B, 1, 0, 0, -1);
      cfg_start = 1'b0;
      load_words("load2", 0);
      step("m3", 1, 7'h2B, 1, 1, 0, -1);
      step("m4", 0, 7'h00, 1, 1, 0, -1);
      step("m5", 0, 7'h00, 1, 1, 1, 3);

`ifdef LUT_PARITY_EN
      // ---- parity: clean read, then a flipped stored bit at entry 5 ----
      step("p0", 1, 7'h05, 1, 1, -1, -1);
      step("p1", 0, 7'h00, 1, 1, -1, -1);
      @(negedge clk);
      chk("p2_out_data", out_data, 1);
      chk("p2_parity_err", parity_err, 0);
      chk("p2_err_sticky", err_sticky, 0);
      adv();
      dut.r_mem[5] = dut.r_mem[5] ^ 3'b001;
      step("p3", 1, 7'h05, 1, 1, -1, -1);
      step("p4", 0, 7'h00, 1, 1, -1, -1);
      @(negedge clk);
      chk("p5_out_valid", out_valid, 1);
      chk("p5_out_data", out_data, 0);
      chk("p5_parity_err", parity_err, 1);
      chk("p5_err_sticky", err_sticky, 1);
      adv();
      @(negedge clk);
      chk("p6_out_valid", out_valid, 0);
      chk("p6_parity_err", parity_err, 0);
      chk("p6_err_sticky", err_sticky, 1);
      adv();
      cfg_start = 1'b1;
      adv();
      cfg_start = 1'b0;
      @(negedge clk);
      chk("p7_err_sticky", err_sticky, 0);
      adv();
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/lut_neuron_pipe.md
Name: lut_neuron_pipe

Overview:
- Parametrised, pipelined successor to the fixed combinational LogicNets neuron LUT: one neuron maps an IN_W-bit fan-in vector to an OUT_W-bit quantised activation.
- The truth table is loaded at run time over a serial config port instead of being hard-coded. Retraining therefore needs no re-synthesis.
- Lookups use a 2-stage registered pipeline with valid/ready handshakes on input and output, so neurons chain layer to layer.

Parameters:
- IN_W, 7, input address width; table depth is 2**IN_W entries.
- OUT_W, 2, output activation width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  pulse: begin (re)loading the table from address 0.
- cfg_valid  input  1  cfg_data holds the next table word.
- cfg_data  input  OUT_W  table word for the current load address.
- cfg_busy  output  1  high in DRAIN or LOAD.
- cfg_done  output  1  one-cycle pulse when the last word is written.
- lut_ready  output  1  high in READY.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  IN_W  fan-in vector (LUT address).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUT_W  activation for the accepted input.

Behaviour:
- Reset (async assert, sync deassert): state = EMPTY; load address = 0; stage valids v1, v2 = 0; out_data = 0. All outputs are 0, including in_ready, cfg_busy, cfg_done and lut_ready.
- Table storage is distributed RAM, 2**IN_W x OUT_W. Reset does not clear it; after reset the table is treated as invalid until a full load completes.
- FSM states: EMPTY, DRAIN, LOAD, READY.
  - EMPTY: cfg_start moves to LOAD with addr = 0.
  - LOAD: each cycle with cfg_valid writes cfg_data to table[addr] and increments addr.
  - LOAD, final write: the write at addr = 2**IN_W-1 pulses cfg_done, moves to READY and wraps addr to 0.
  - LOAD, restart: cfg_start in LOAD restarts at addr 0. Words already written stay, but completion needs a full pass. When cfg_start and cfg_valid occur together, the word is written to addr 0 and addr becomes 1.
  - READY: cfg_start moves to DRAIN.
  - DRAIN: in_ready = 0. Once v1 = v2 = 0 (pipeline flushed by out_ready), move to LOAD with addr = 0. The flush takes the same cycle if the pipeline is already empty.
- cfg_valid outside LOAD is ignored.
- Pipeline enables:
  - en2 = !v2 | out_ready.
  - en1 = !v1 | en2.
  - in_ready = (state == READY) & en1. This is a combinational path from out_ready, and it is intended.
- Pipeline stages:
  - Stage 1: on in_valid & in_ready, register in_data and set v1. If en1 and no accept, clear v1.
  - Stage 2: on en2, out_data <= table[addr1] and v2 <= v1.
  - out_valid = v2.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure. Throughput is 1 per cycle.
- Backpressure: while out_valid & !out_ready, out_data and out_valid hold stable. Stage 1 holds if full, and in_ready drops when both stages are full.
- Reset mid-load returns to EMPTY; the partial table is unusable. Reset mid-stream drops in-flight lookups.
- A table write and a lookup never coincide, because lookups are only accepted in READY.

Optional Feature:
- Macro: LUT_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit computed at write time.
  - A stage-2 read recomputes parity, and on mismatch asserts the extra output parity_err (1 bit, aligned with out_valid, reset 0), held with out_data.
  - parity_err is sticky in err_sticky (extra output), cleared only by rst or cfg_start.
- Not defined: no extra storage bit; parity_err and err_sticky ports do not exist.

Test Plan:
- Reset, then cfg_start and 128 words with table[i] = i % 4 -> cfg_done pulses once on the cycle of the word at addr 127. lut_ready = 1 the next cycle. cfg_busy is high throughout the load.
- Stream in_data 0x2B, 0x04, 0x7F back-to-back with out_ready = 1 -> out_data 3, 0, 3 on cycles +2, +3, +4, with out_valid continuous.
- Hold out_ready = 0 for 5 cycles during a stream -> in_ready falls after 2 accepts. out_data holds at the first result; no loss or duplication after release.
- cfg_start while 2 lookups are in flight and out_ready = 0 -> state DRAIN, in_ready = 0. LOAD starts only after both results are consumed. Reload with table[i] = 3 - i % 4, then in_data 0x2B -> 0.
- Assert rst at load addr 60 -> all outputs 0. in_ready stays 0 until a full 128-word load completes.
- With LUT_PARITY_EN defined, force a stored bit flip at entry 5 via backdoor, then look up 5 -> parity_err = 1 aligned with out_valid and err_sticky = 1. A following cfg_start clears err_sticky.
